bin_to_bcd: RTL and testbench

- Iterative binary-to-BCD converter using shift-and-add-3 (double-dabble).
- Produces packed BCD digits for the banner's per-digit seven-segment decoders.
- Converts an unsigned binary count (score, counter, timer) into DIGITS decimal digits.
- Also outputs leading-zero flags so display logic can blank unused digits.

---
 rtl/bin_to_bcd.sv | 154 +++++++++++++++
 tb/tb_bin_to_bcd.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Ports: clk, rst_n (sync, active low), start/bin_in in; busy, done, bcd_out, overflow, lz out.
module bin_to_bcd #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz
);

    // Scratch must hold every digit of 2**BIN_WIDTH-1, and at least DIGITS.
    function automatic int scr_nibbles(input int bw, input int dg);
        longint v;
        int     n;
        v = (longint'(1) << bw) - 1;
        n = 0;
        while (v > 0) begin
            n++;
            v = v / 10;
        end
        return (n > dg) ? n : dg;
    endfunction

    localparam int SCR_N = scr_nibbles(BIN_WIDTH, DIGITS);
    localparam int SW    = 4 * SCR_N;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [SW-1:0]          scr_q, scr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;
    logic [DIGITS-1:0]      lz_q, lz_d;

    logic [SW-1:0]          scr_adj;
    logic [SW-1:0]          scr_sh;
    logic [BIN_WIDTH-1:0]   bin_sh;
    logic                   ovf_c;
    logic [4*DIGITS-1:0]    res_c;
    logic [DIGITS-1:0]      lz_c;

    // One double-dabble step: correct nibbles >= 5, then shift left.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < SCR_N; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        scr_sh = {scr_adj[SW-2:0], bin_q[BIN_WIDTH-1]};
        bin_sh = {bin_q[BIN_WIDTH-2:0], 1'b0};
    end

    // Result of the final step: saturation and leading-zero flags.
    always_comb begin
        ovf_c = 1'b0;
        for (int i = DIGITS; i < SCR_N; i++) begin
            if (scr_sh[4*i +: 4] != 4'h0) begin
                ovf_c = 1'b1;
            end
        end
        res_c = ovf_c ? {DIGITS{4'h9}} : scr_sh[4*DIGITS-1:0];
        lz_c = '0;
        lz_c[DIGITS-1] = (res_c[4*DIGITS-4 +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 1; i--) begin
            lz_c[i] = lz_c[i+1] && (res_c[4*i +: 4] == 4'h0);
        end
        // Ones digit always displays, even for zero.
        lz_c[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        lz_d    = lz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    bin_d   = bin_in;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_WIDTH);
                end
            end
            SHIFT: begin
                bin_d = bin_sh;
                scr_d = scr_sh;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    bcd_d   = res_c;
                    ovf_d   = ovf_c;
                    lz_d    = lz_c;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            lz_q    <= LZ_RST;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            lz_q    <= lz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
    assign lz       = lz_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed testbench for bin_to_bcd (BIN_WIDTH=14, DIGITS=4).
// Each task drives one scenario and checks its own results.
module tb_bin_to_bcd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;
    logic [3:0]  lz;

    int tests;
    int fails;

    bin_to_bcd #(.BIN_WIDTH(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .lz       (lz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start across one rising edge (edge 0), return #1 after it.
    task automatic do_start(input logic [13:0] v);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 14'h3fff;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, overflow} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, overflow});
        end
        tests++;
        if (bcd_out !== 16'h0000 || lz !== 4'b1110) begin
            fails++;
            $display("FAIL reset_data: got bcd=%h lz=%b expected 0000/1110", bcd_out, lz);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_latency();
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [15:0] b;
        logic [3:0]  l;
        logic        o;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        b = 16'hxxxx;
        l = 4'hx;
        o = 1'bx;
        do_start(14'd0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL zero_busy_rise: got %b expected 1", busy);
        end
        if (busy === 1'b1) busy_cnt++;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    b = bcd_out;
                    l = lz;
                    o = overflow;
                end
            end
        end
        // done must appear after the 15th edge counting the start edge.
        tests++;
        if (done_at != 14) begin
            fails++;
            $display("FAIL zero_latency: got edge %0d expected 14", done_at);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL zero_done_count: got %0d expected 1", done_cnt);
        end
        tests++;
        if (busy_cnt != 14) begin
            fails++;
            $display("FAIL zero_busy_cycles: got %0d expected 14", busy_cnt);
        end
        tests++;
        if (b !== 16'h0000 || l !== 4'b1110 || o !== 1'b0) begin
            fails++;
            $display("FAIL zero_result: got %h/%b/%b expected 0000/1110/0", b, l, o);
        end
    endtask

    task automatic test_values();
        logic [13:0] vin [5];
        logic [15:0] vbcd [5];
        logic [3:0]  vlz [5];
        logic        vovf [5];
        vin[0] = 14'd9999;  vbcd[0] = 16'h9999; vlz[0] = 4'b0000; vovf[0] = 1'b0;
        vin[1] = 14'd1234;  vbcd[1] = 16'h1234; vlz[1] = 4'b0000; vovf[1] = 1'b0;
        vin[2] = 14'd305;   vbcd[2] = 16'h0305; vlz[2] = 4'b1000; vovf[2] = 1'b0;
        vin[3] = 14'd7;     vbcd[3] = 16'h0007; vlz[3] = 4'b1110; vovf[3] = 1'b0;
        vin[4] = 14'd12000; vbcd[4] = 16'h9999; vlz[4] = 4'b0000; vovf[4] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int got;
            got = 0;
            do_start(vin[k]);
            for (int c = 1; c <= 20 && got == 0; c++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) got = c;
            end
            tests++;
            if (got != 14) begin
                fails++;
                $display("FAIL val_%0d_timing: got edge %0d expected 14", vin[k], got);
            end
            tests++;
            if (bcd_out !== vbcd[k] || lz !== vlz[k] || overflow !== vovf[k]) begin
                fails++;
                $display("FAIL val_%0d: got %h/%b/%b expected %h/%b/%b", vin[k],
                         bcd_out, lz, overflow, vbcd[k], vlz[k], vovf[k]);
            end
        end
    endtask

    task automatic test_overflow_clear();
        int got;
        got = 0;
        do_start(14'd42);
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) got = c;
        end
        tests++;
        if (got == 0 || bcd_out !== 16'h0042 || overflow !== 1'b0 || lz !== 4'b1100) begin
            fails++;
            $display("FAIL ovf_clear: got edge %0d %h/%b/%b expected 14 0042/1100/0",
                     got, bcd_out, lz, overflow);
        end
    endtask

    task automatic test_ignore_busy();
        int done_cnt;
        int hold_bad;
        logic [15:0] b;
        done_cnt = 0;
        hold_bad = 0;
        b = 16'hxxxx;
        do_start(14'd100);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1 && bcd_out !== 16'h0042) hold_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                b = bcd_out;
            end
            if (c == 4) begin
                start  = 1'b1;
                bin_in = 14'd55;
            end else begin
                start = 1'b0;
            end
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL ignore_busy_count: got %0d expected 1", done_cnt);
        end
        tests++;
        if (b !== 16'h0100) begin
            fails++;
            $display("FAIL ignore_busy_value: got %h expected 0100", b);
        end
        tests++;
        if (hold_bad != 0) begin
            fails++;
            $display("FAIL hold_during_shift: got %0d changed cycles expected 0", hold_bad);
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        first  = 0;
        second = 0;
        do_start(14'd100);
        for (int c = 1; c <= 40 && second == 0; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                if (first == 0) begin
                    first  = c;
                    start  = 1'b1;
                    bin_in = 14'd55;
                end else begin
                    second = c;
                end
            end
        end
        tests++;
        if (first != 14 || second != 29) begin
            fails++;
            $display("FAIL b2b_timing: got edges %0d,%0d expected 14,29", first, second);
        end
        tests++;
        if (bcd_out !== 16'h0055 || lz !== 4'b1100) begin
            fails++;
            $display("FAIL b2b_value: got %h/%b expected 0055/1100", bcd_out, lz);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        int got;
        done_cnt = 0;
        got = 0;
        do_start(14'd9876);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        tests++;
        if (busy !== 1'b0 || bcd_out !== 16'h0000 || lz !== 4'b1110 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_state: got busy=%b %h/%b/%b expected 0 0000/1110/0",
                     busy, bcd_out, lz, overflow);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        tests++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", done_cnt);
        end
        do_start(14'd321);
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) got = c;
        end
        tests++;
        if (got != 14 || bcd_out !== 16'h0321 || lz !== 4'b1000) begin
            fails++;
            $display("FAIL reset_mid_recover: got edge %0d %h/%b expected 14 0321/1000",
                     got, bcd_out, lz);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        test_reset();
        test_zero_latency();
        test_values();
        test_overflow_clear();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
